// File: rtl/vga_pkg.sv
// Shared encodings, default 640x480@60 timing and the pixel colour mapping
// for the VGA stream display.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_RAW  = 2'd0,
    MODE_THR  = 2'd1,
    MODE_GRAY = 2'd2,
    MODE_INV  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_STARTUP  = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_RESYNC   = 2'd3
  } state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Gray weights are 1:2:1 on the 8-bit-scaled channels; sum peaks at 1000.
  function automatic logic [15:0] map_pixel(mode_e m, logic thr_hit, logic [15:0] rgb);
    logic [9:0]  sum;
    logic [7:0]  gray;
    logic [15:0] res;
    sum  = {2'b00, rgb[15:11], 3'b000} + {1'b0, rgb[10:5], 3'b000} + {2'b00, rgb[4:0], 3'b000};
    gray = sum[9:2];
    res  = rgb;
    case (m)
      MODE_RAW:  res = rgb;
      MODE_THR:  res = thr_hit ? 16'hFFFF : 16'h0000;
      MODE_GRAY: res = {gray[7:3], gray[7:2], gray[7:3]};
      MODE_INV:  res = thr_hit ? 16'h0000 : 16'hFFFF;
      default:   res = rgb;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/vga_stream_display_if.sv
// Pixel FIFO read port seen by the display (FIFO side = master).
// fifo_din is valid whenever fifo_empty is low (first-word-fall-through);
// a word is consumed in every cycle where fifo_rd_en is high.
interface vga_stream_display_if #(
  parameter int PIX_W = 16
);
  logic             fifo_empty;
  logic [PIX_W-1:0] fifo_din;
  logic             fifo_rd_en;

  modport master (output fifo_empty, output fifo_din, input fifo_rd_en);
  modport slave  (input fifo_empty, input fifo_din, output fifo_rd_en);
endinterface

// File: rtl/vga_timing.sv
// Free-running h/v raster counters with sync, active-area and frame-end decode.
// All outputs are combinational from the current counter state.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk_out,
  input  logic rst_n,
  output logic active,
  output logic hs_n,
  output logic vs_n,
  output logic frame_end,
  output logic first_px
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_wrap;

  always_comb begin
    h_wrap    = (h_q == HW'(H_TOTAL - 1));
    frame_end = h_wrap && (v_q == VW'(V_TOTAL - 1));
    h_d       = h_wrap ? '0 : h_q + HW'(1);
    v_d       = v_q;
    if (frame_end)   v_d = '0;
    else if (h_wrap) v_d = v_q + VW'(1);
    active   = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    hs_n     = !((int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC));
    vs_n     = !((int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC));
    first_px = (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

endmodule

// File: rtl/vga_stream_display.sv
// Streams FIFO pixels onto a VGA raster: start-up blanking, frame-locked
// start, underflow recovery and per-frame display mode selection.
module vga_stream_display
  import vga_pkg::*;
#(
  parameter int H_ACTIVE       = DEF_H_ACTIVE,
  parameter int H_FP           = DEF_H_FP,
  parameter int H_SYNC         = DEF_H_SYNC,
  parameter int H_BP           = DEF_H_BP,
  parameter int V_ACTIVE       = DEF_V_ACTIVE,
  parameter int V_FP           = DEF_V_FP,
  parameter int V_SYNC         = DEF_V_SYNC,
  parameter int V_BP           = DEF_V_BP,
  parameter int PIX_W          = 16,
  parameter int STARTUP_FRAMES = 1
) (
  input  logic                       clk_out,
  input  logic                       rst_n,
  input  logic [1:0]                 mode,
  input  logic [7:0]                 threshold,
  input  logic                       underflow_clr,
  vga_stream_display_if.slave        fifo,
  output logic [4:0]                 vga_r,
  output logic [5:0]                 vga_g,
  output logic [4:0]                 vga_b,
  output logic                       vga_hs,
  output logic                       vga_vs,
  output logic                       underflow,
  output logic                       frame_start,
  output state_e                     dbg_state
);
  localparam int SW = (STARTUP_FRAMES > 1) ? $clog2(STARTUP_FRAMES) : 1;

  logic   active, hs_c, vs_c, frame_end, first_px;
  state_e state_q, state_d;
  logic [SW-1:0] start_cnt_q, start_cnt_d;
  mode_e  mode_q, mode_d;
  logic [7:0]  thr_q, thr_d;
  logic [15:0] rgb_q, rgb_d;
  logic   hs_q, vs_q, uf_q, uf_d, fs_q, fs_d;
  logic   rd_en, show, uf_set, thr_hit;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_out  (clk_out),
    .rst_n    (rst_n),
    .active   (active),
    .hs_n     (hs_c),
    .vs_n     (vs_c),
    .frame_end(frame_end),
    .first_px (first_px)
  );

  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    mode_d      = mode_q;
    thr_d       = thr_q;
    rd_en       = 1'b0;
    show        = 1'b0;
    uf_set      = 1'b0;
    if (frame_end) begin
      mode_d = mode_e'(mode);
      thr_d  = threshold;
    end
    unique case (state_q)
      // The last start-up frame end doubles as the first start-of-frame
      // check, so the frame right after the blanking window is shown.
      ST_STARTUP: begin
        if (STARTUP_FRAMES == 0) begin
          state_d = ST_WAIT_SOF;
        end else if (frame_end) begin
          if (start_cnt_q == SW'(STARTUP_FRAMES - 1)) begin
            state_d = fifo.fifo_empty ? ST_WAIT_SOF : ST_ACTIVE;
          end else begin
            start_cnt_d = start_cnt_q + SW'(1);
          end
        end
      end
      ST_WAIT_SOF: if (frame_end && !fifo.fifo_empty) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (active) begin
          if (fifo.fifo_empty) begin
            uf_set  = 1'b1;
            state_d = ST_RESYNC;
          end else begin
            rd_en = 1'b1;
            show  = 1'b1;
          end
        end
      end
      ST_RESYNC: if (frame_end) state_d = ST_WAIT_SOF;
      default: state_d = ST_STARTUP;
    endcase
    thr_hit = fifo.fifo_din > PIX_W'(thr_q);
    rgb_d   = show ? map_pixel(mode_q, thr_hit, fifo.fifo_din[15:0]) : 16'h0000;
    fs_d    = (state_q == ST_ACTIVE) && first_px;
    uf_d    = uf_set ? 1'b1 : (underflow_clr ? 1'b0 : uf_q);
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_STARTUP;
      start_cnt_q <= '0;
      mode_q      <= MODE_RAW;
      thr_q       <= '0;
      rgb_q       <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      uf_q        <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_c;
      vs_q        <= vs_c;
      uf_q        <= uf_d;
      fs_q        <= fs_d;
    end
  end

  assign fifo.fifo_rd_en = rd_en;
  assign vga_r       = rgb_q[15:11];
  assign vga_g       = rgb_q[10:5];
  assign vga_b       = rgb_q[4:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign underflow   = uf_q;
  assign frame_start = fs_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vga_stream_display.sv
// Directed bench for vga_stream_display on a shrunken 8x6 raster
// (15x10 totals) so each frame is only 150 pixel clocks.
module tb_vga_stream_display;
  import vga_pkg::*;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  // clock / reset
  logic clk_out = 1'b0;
  logic rst_n   = 1'b1;
  always #5 clk_out = ~clk_out;

  logic [1:0]  mode = 2'd0;
  logic [7:0]  threshold = 8'd0;
  logic        underflow_clr = 1'b0;
  logic        empty = 1'b0;
  logic [15:0] pat_a = 16'h0000, pat_b = 16'h0000;
  logic [4:0]  vga_r, vga_b;
  logic [5:0]  vga_g;
  logic        vga_hs, vga_vs, underflow, frame_start;
  state_e      dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc, pops;

  vga_stream_display_if #(.PIX_W(16)) ff ();

  vga_stream_display #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIX_W(16), .STARTUP_FRAMES(1)
  ) dut (
    .clk_out      (clk_out),
    .rst_n        (rst_n),
    .mode         (mode),
    .threshold    (threshold),
    .underflow_clr(underflow_clr),
    .fifo         (ff),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .underflow    (underflow),
    .frame_start  (frame_start),
    .dbg_state    (dbg_state)
  );

  // FIFO model: pops alternate between two pattern words
  assign ff.fifo_empty = empty;
  assign ff.fifo_din   = pops[0] ? pat_b : pat_a;

  always @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      cyc  <= 0;
      pops <= 0;
    end else begin
      cyc <= cyc + 1;
      if (ff.fifo_rd_en) pops <= pops + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_out);
    rst_n = 1'b1;
  endtask

  // pins show pixel p (counted from reset release) once cyc == p+1
  task automatic wait_pix(input int p);
    int guard;
    guard = 0;
    while (cyc < p + 1 && guard < 2000) begin
      @(negedge clk_out);
      guard++;
    end
    if (cyc != p + 1) check("wait_pix", cyc, p + 1);
  endtask

  task automatic scan_frame(input string tag, input int f, input logic [15:0] ea,
                            input logic [15:0] eb, input bit fs_exp,
                            input int empty_pix, input int new_mode);
    int bad_rgb, bad_hs, bad_vs, bad_fs, hs_lo, vs_lo, k;
    bit dead;
    bad_rgb = 0; bad_hs = 0; bad_vs = 0; bad_fs = 0; hs_lo = 0; vs_lo = 0; k = 0;
    dead = 1'b0;
    for (int i = 0; i < FT; i++) begin
      int h, v;
      bit vis;
      logic [15:0] exp_rgb;
      h = i % HT;
      v = i / HT;
      vis = (h < HA) && (v < VA);
      wait_pix(f * FT + i);
      if (i == empty_pix) dead = 1'b1;
      exp_rgb = (!vis || dead) ? 16'h0000 : ((k % 2 == 0) ? ea : eb);
      if (vis) k++;
      if ({vga_r, vga_g, vga_b} !== exp_rgb) bad_rgb++;
      if (vga_hs !== !((h >= HA + HF) && (h < HA + HF + HS))) bad_hs++;
      if (vga_vs !== !((v >= VA + VF) && (v < VA + VF + VS))) bad_vs++;
      if (!vga_hs) hs_lo++;
      if (!vga_vs) vs_lo++;
      if (frame_start !== (fs_exp && i == 0)) bad_fs++;
      empty = (i + 1 == empty_pix);
      if (new_mode >= 0 && i == FT / 2) mode = new_mode[1:0];
    end
    check({tag, "_rgb"}, bad_rgb, 0);
    check({tag, "_hs_align"}, bad_hs, 0);
    check({tag, "_vs_align"}, bad_vs, 0);
    check({tag, "_hs_width"}, hs_lo, HS * VT);
    check({tag, "_vs_width"}, vs_lo, VS * HT);
    check({tag, "_frame_start"}, bad_fs, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // raw mode, solid red, reset values checked before any clock edge
    mode = 2'd0; pat_a = 16'hF800; pat_b = 16'hF800;
    #1 rst_n = 1'b0;
    #2;
    check("rst_rgb", {vga_r, vga_g, vga_b}, 16'h0000);
    check("rst_hs_vs", {vga_hs, vga_vs}, 2'b11);
    check("rst_uf_fs", {underflow, frame_start}, 2'b00);
    check("rst_rd_en", ff.fifo_rd_en, 1'b0);
    check("rst_state", dbg_state, ST_STARTUP);
    repeat (3) @(negedge clk_out);
    rst_n = 1'b1;
    scan_frame("a_f0", 0, 16'h0000, 16'h0000, 1'b0, -1, -1);
    scan_frame("a_f1", 1, 16'hF800, 16'hF800, 1'b1, -1, -1);
    check("a_pops", pops, HA * VA);

    // threshold 0x40 on 0x0041/0x0040, switched to inverted mid-frame
    mode = 2'd1; threshold = 8'h40; pat_a = 16'h0041; pat_b = 16'h0040;
    do_reset();
    scan_frame("b_f0", 0, 16'h0000, 16'h0000, 1'b0, -1, -1);
    scan_frame("b_f1", 1, 16'hFFFF, 16'h0000, 1'b1, -1, 3);
    scan_frame("b_f2", 2, 16'h0000, 16'hFFFF, 1'b1, -1, -1);

    // grayscale: 0xFFFF -> 31/62/31, 0x0000 -> black
    mode = 2'd2; pat_a = 16'hFFFF; pat_b = 16'h0000;
    do_reset();
    scan_frame("c_f0", 0, 16'h0000, 16'h0000, 1'b0, -1, -1);
    scan_frame("c_f1", 1, 16'hFFDF, 16'h0000, 1'b1, -1, -1);

    // underflow at pixel 3 of line 2 in frame 1
    mode = 2'd0; pat_a = 16'h07E0; pat_b = 16'h07E0;
    do_reset();
    scan_frame("d_f0", 0, 16'h0000, 16'h0000, 1'b0, -1, -1);
    scan_frame("d_f1", 1, 16'h07E0, 16'h07E0, 1'b1, 2 * HT + 3, -1);
    check("d_uf_set", underflow, 1'b1);
    check("d_pops_stop", pops, 2 * HA + 3);
    check("d_state_wait", dbg_state, ST_WAIT_SOF);
    scan_frame("d_f2", 2, 16'h0000, 16'h0000, 1'b0, -1, -1);
    check("d_pops_blank", pops, 2 * HA + 3);
    check("d_uf_sticky", underflow, 1'b1);
    underflow_clr = 1'b1;
    @(negedge clk_out);
    underflow_clr = 1'b0;
    check("d_uf_clr", underflow, 1'b0);
    scan_frame("d_f3", 3, 16'h07E0, 16'h07E0, 1'b1, -1, -1);
    check("d_pops_resync", pops, 2 * HA + 3 + HA * VA);

    // asynchronous reset in the middle of frame 4 while both syncs are low
    wait_pix(4 * FT + 7 * HT + 11);
    check("e_pre_sync", {vga_hs, vga_vs}, 2'b00);
    check("e_pre_state", dbg_state, ST_ACTIVE);
    #2 rst_n = 1'b0;
    #1;
    check("e_rst_sync", {vga_hs, vga_vs}, 2'b11);
    check("e_rst_state", dbg_state, ST_STARTUP);
    repeat (2) @(negedge clk_out);
    check("e_rst_rd_en", ff.fifo_rd_en, 1'b0);
    check("e_rst_rgb", {vga_r, vga_g, vga_b}, 16'h0000);
    rst_n = 1'b1;
    scan_frame("e_f0", 0, 16'h0000, 16'h0000, 1'b0, -1, -1);
    scan_frame("e_f1", 1, 16'h07E0, 16'h07E0, 1'b1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_stream_display.md
VGA_STREAM_DISPLAY -- requirements
Module: vga_stream_display

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameters V_FP/V_SYNC/V_BP, 10/2/33, vertical porch and sync widths in lines.
REQ-005 Parameter PIX_W, 16, FIFO word width; RGB565 occupies bits [15:0].
REQ-006 Parameter STARTUP_FRAMES, 1, frames blanked after reset for camera start-up.
REQ-007 clk_out  in  1  pixel clock; reset rst_n, asynchronous, active-low.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 mode  in  2  display mode: 0 raw RGB, 1 threshold, 2 grayscale, 3 inverted threshold.
REQ-010 threshold  in  8  edge threshold for modes 1/3.
REQ-011 fifo_empty  in  1  FIFO empty; fifo_din valid whenever low (first-word-fall-through).
REQ-012 fifo_din  in  PIX_W  pixel word.
REQ-013 fifo_rd_en  out  1  pop request, combinational.
REQ-014 vga_r/vga_g/vga_b  out  5/6/5  registered colour.
REQ-015 vga_hs/vga_vs  out  1  registered syncs, active-low.
REQ-016 underflow  out  1  sticky underflow flag.
REQ-017 underflow_clr  in  1  clears underflow.
REQ-018 frame_start  out  1  one-cycle pulse, aligned with first visible pixel on the VGA pins.

Function
REQ-019 Counters: h 0..H_TOTAL-1, v 0..V_TOTAL-1, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; v increments on h wrap; both wrap to 0 together.
REQ-020 active = (h < H_ACTIVE) && (v < V_ACTIVE); hs low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs likewise on v.
REQ-021 Colour, hs, vs and frame_start are registered once, so all have exactly 1 cycle latency from the counter state.
REQ-022 Colour is 0 whenever not active or not in state ACTIVE.
REQ-023 FSM states: STARTUP, WAIT_SOF, ACTIVE, RESYNC.
REQ-024 STARTUP: count frame ends (h=H_TOTAL-1, v=V_TOTAL-1); after STARTUP_FRAMES go to WAIT_SOF; STARTUP_FRAMES=0 enters WAIT_SOF directly.
REQ-025 WAIT_SOF: at frame end, if fifo_empty=0 go to ACTIVE, else remain and blank the next frame.
REQ-026 ACTIVE: fifo_rd_en = active && !fifo_empty; never asserted outside active.
REQ-027 ACTIVE underflow (active && fifo_empty): output black, set underflow, go to RESYNC.
REQ-028 RESYNC: fifo_rd_en=0, output black; at frame end go to WAIT_SOF.
REQ-029 mode_q and threshold_q are sampled only at frame end; mid-frame changes take effect on the next frame.
REQ-030 Raw: r=din[15:11], g=din[10:5], b=din[4:0].
REQ-031 Threshold: white (all ones) if unsigned fifo_din > zero-extended threshold_q, else black; mode 3 inverts the result.
REQ-032 Grayscale: gray = ({R,3'b0} + 2*{G,2'b0} + {B,3'b0}) >> 2 with a 10-bit intermediate; result max 250 fits 8 bits; r=gray[7:3], g=gray[7:2], b=gray[7:3].
REQ-033 underflow set and underflow_clr in the same cycle: set wins.
REQ-034 frame_start pulses only when the FSM enters ACTIVE or stays in ACTIVE at frame end.

Reset
REQ-035 rst_n low: state=STARTUP, h=v=0, startup counter=0, colour=0, vga_hs=vga_vs=1, underflow=0, frame_start=0, mode_q=0, threshold_q=0.
REQ-036 Reset mid-frame aborts the frame immediately; fifo_rd_en=0 throughout reset; after release timing restarts at h=v=0.

Structure
REQ-037 Package vga_pkg holds mode encodings, FSM state encoding and default 640x480@60 timing constants.
REQ-038 Sub-module vga_timing holds counters, sync generation, active, and a frame-end strobe; the FSM, colour path and flags live in the top.

Verification
REQ-039 Reset, STARTUP_FRAMES=1, FIFO always full of 16'hF800, mode 0 -> frame 0 black; frame 1 outputs r=31 g=0 b=0 for all 307200 pixels; exactly 307200 pops.
REQ-040 Mode 1, threshold 8'h40, pixels alternating 16'h0041/16'h0040 -> alternating white/black; mode 3 -> inverted.
REQ-041 Mode 2, din=16'hFFFF -> gray=250, r=31 g=62 b=31; din=0 -> all 0.
REQ-042 FIFO empties at pixel 100 of line 5 -> that pixel black, underflow=1, no pops until the next frame end, resync on the next non-empty frame; underflow_clr then clears the flag.
REQ-043 Mode changed mid-frame -> current frame unchanged; next frame uses the new mode.
REQ-044 Check hs/vs widths of 96 pixels and 2 lines, 800x525 totals, and 1-cycle colour/sync alignment; assert rst_n mid-frame -> outputs reach reset values asynchronously.
